sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_if.sv | 32 +++
 rtl/sw_debounce.sv | 83 ++++++++
 2 files changed

// File: rtl/sw_debounce_if.sv
// Switch debouncer bus: raw switch vector and freeze control in,
// committed vector, change pulse, busy flag and commit counter out.
//
// Handshake: there is no valid/ready pair on this bus. sw and hold are
// level inputs sampled on every rising clk edge. chg is a one-cycle
// strobe marking the cycle in which a takes a new value.
interface sw_debounce_if;
    logic [7:0] sw;
    logic       hold;
    logic [7:0] a;
    logic       chg;
    logic       busy;
    logic [7:0] evt_cnt;

    modport master (
        output sw,
        output hold,
        input  a,
        input  chg,
        input  busy,
        input  evt_cnt
    );

    modport slave (
        input  sw,
        input  hold,
        output a,
        output chg,
        output busy,
        output evt_cnt
    );
endinterface

// File: rtl/sw_debounce.sv
// Eight-bit switch debouncer. The raw vector is synchronised through two
// flops, then must stay unchanged for THRESH consecutive samples before
// it is committed to the output. hold freezes the committed vector; a
// commit that matures while hold is high is taken on the first edge
// after hold drops. THRESH must lie in 2..65535 and 2**CNT_W > THRESH.
module sw_debounce #(
    parameter int THRESH = 20000,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    sw_debounce_if.slave  bus
);

    // Count value at which the candidate has been seen THRESH times.
    localparam logic [CNT_W-1:0] SAT = CNT_W'(THRESH - 1);

    logic [7:0]       s1_q, s2_q;
    logic [7:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       a_q, a_d;
    logic             chg_q, chg_d;
    logic [7:0]       evt_q, evt_d;

    // Two-flop synchroniser; nothing else looks at the raw switch input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.sw;
            s2_q <= s1_q;
        end
    end

    // Candidate tracking, stability counting and commit decision.
    // A change of the synchronised input always restarts the count,
    // even when the counter is saturated on the same edge.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        chg_d  = 1'b0;
        evt_d  = evt_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q < SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if ((cand_q != a_q) && !bus.hold) begin
            a_d   = cand_q;
            chg_d = 1'b1;
            evt_d = evt_q + 8'd1;
        end
    end

    // Debounce state registers; reset discards any pending candidate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q <= '0;
            cnt_q  <= '0;
            a_q    <= '0;
            chg_q  <= 1'b0;
            evt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            chg_q  <= chg_d;
            evt_q  <= evt_d;
        end
    end

    // Busy while a different vector is being qualified.
    always_comb begin
        bus.busy = (cand_q != a_q);
    end

    assign bus.a       = a_q;
    assign bus.chg     = chg_q;
    assign bus.evt_cnt = evt_q;

endmodule
